control_pipeline_unit: RTL and testbench
========================================

// Module: control_pipeline_unit
// PURPOSE
//  Pipelined successor of the decode-stage control unit: decodes the ID-stage opcode into control bundles.
//  Carries the bundles through ID/EX, EX/MEM and MEM/WB registers with per-stage valid bits.
//  Adds stall hold, flush/bubble insertion, illegal-opcode flagging and load-use hazard detection.
//  Sits between the decoder and the EX/MEM/WB datapath; the datapath reads only the registered stage outputs.
// PARAMETERS
//  REG_ADDR_W  5  register index width (rd/rs1/rs2)
//  ALU_OP_W    3  aluOperation width; must be >= 3
// PORTS
//  clk                    in   1          single clock, rising edge
//  resetN                 in   1          asynchronous, active-low reset
//  idValid                in   1          ID holds a real instruction
//  opcode                 in   7          ID opcode
//  idRd/idRs1/idRs2       in   REG_ADDR_W ID register indices
//  stall                  in   1          external freeze of all stages
//  flush                  in   1          squash ID/EX entry (taken branch/jump)
//  exValid/memValid/wbValid out 1         stage occupancy
//  exAluSrc1/exAluSrc2    out  2          00 reg|01 pc|10 const0 ; 00 reg|01 imm|10 const1
//  exAluOperation         out  ALU_OP_W   ALU op code
//  exPcUpdate/exPcAdderSrc out 1          branch/jump; adder base 0=pc 1=reg
//  exRd                   out  REG_ADDR_W EX destination (hazard check and forwarding)
//  memReadEnable/memWriteEnable out 1     MEM stage controls
//  memRd                  out  REG_ADDR_W MEM destination
//  wbRegWriteEnable/wbFromMemory out 1    WB controls; 0=ALU 1=memory
//  wbRd                   out  REG_ADDR_W WB destination
//  loadUseStall           out  1          comb.: hold PC/IF/ID this cycle
//  illegalOpcode          out  1          registered with EX; unknown opcode seen
// BEHAVIOUR
//  Decode table (comb., then registered into ID/EX):
//   R 0110011: regWr, src 00/00, op 010.  I 0010011: regWr, 00/01, op 011.
//   LOAD 0000011: memRd, regWr, fromMem, 00/01, op 000.  S 0100011: memWr, 00/01, op 000.
//   B 1100011: pcUpd, 00/00, op 001, adderSrc 0.  JAL 1101111: pcUpd, regWr, 01/10, op 100, adderSrc 0.
//   JALR 1100111: pcUpd, regWr, 01/10, op 101, adderSrc 1.  LUI 0110111: regWr, 10/01, op 110.
//   AUIPC 0010111: regWr, 01/01, op 111.
//   Unlisted opcode: decodes as a bubble and sets illegalOpcode for 1 cycle, aligned with EX.
//  Reset (resetN=0, async): all stage registers, valids, exRd/memRd/wbRd and illegalOpcode clear to 0.
//  Bubble: valid=0 and every control/rd field 0; all enable outputs are 0 whenever their valid is 0.
//  Latency: ID decode reaches EX outputs in +1 cycle, MEM in +2, WB in +3.
//  Per-edge priority: resetN > stall > flush > loadUseStall > normal advance.
//   stall=1: every stage holds, including any pending flush target. illegalOpcode holds.
//   flush=1 (stall=0): ID/EX loads a bubble; EX->MEM and MEM->WB advance.
//   loadUseStall=1: ID/EX loads a bubble; the later stages advance; upstream holds ID.
//  loadUseStall = exValid & memReadEnable_EX & exRd!=0 & idValid & (usesRs1&exRd==idRs1 | usesRs2&exRd==idRs2).
//   Source use: R/S/B use rs1+rs2; I/LOAD/JALR use rs1; JAL/LUI/AUIPC use none.
//   It is combinational from ID/EX state plus ID inputs, and is forced 0 while stall or flush is 1.
//  rd with index 0: wbRegWriteEnable is still driven. The regfile ignores writes to x0.
//  Reset deasserted mid-pipeline: the pipeline restarts empty; no partial state survives.
// CONFIGURATION
//  HAZARD_DETECT_EN defined: load-use detection and bubble insertion as above.
//  HAZARD_DETECT_EN undefined: loadUseStall tied 0 and no hazard logic is built. Scheduling is the compiler's job.
// TESTING
//  Reset: resetN=0 mid-stream -> all outputs 0 immediately (asynchronous), valids 0.
//  R stream: opcode 0110011, idValid=1 -> cycle+1 exAluOperation=010, srcs 00/00; cycle+3 wbRegWriteEnable=1.
//  Load-use: LOAD rd=5, then R rs1=5 -> loadUseStall=1 for 1 cycle; one bubble in EX; R reaches EX a cycle later.
//   With HAZARD_DETECT_EN undefined the same sequence gives loadUseStall=0.
//  No-hazard cases: LOAD rd=0 followed by rs1=0, or LOAD rd=5 followed by LUI -> loadUseStall=0.
//  Flush: JAL in EX plus flush=1 -> next cycle exValid=0, memValid=1 with JAL controls.
//   flush and stall together -> all stages hold.
//  Illegal: opcode 1111111 -> next cycle illegalOpcode=1, exValid=0, all enables 0.

Source files
------------

// File: rtl/control_pipeline_unit.sv
// Pipelined control unit: decodes the ID opcode and carries control bundles through ID/EX, EX/MEM, MEM/WB.
// Define HAZARD_DETECT_EN to build load-use hazard detection; otherwise loadUseStall is tied low.
module control_pipeline_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALU_OP_W   = 3
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  idValid,
  input  logic [6:0]            opcode,
  input  logic [REG_ADDR_W-1:0] idRd,
  input  logic [REG_ADDR_W-1:0] idRs1,
  input  logic [REG_ADDR_W-1:0] idRs2,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  exValid,
  output logic                  memValid,
  output logic                  wbValid,
  output logic [1:0]            exAluSrc1,
  output logic [1:0]            exAluSrc2,
  output logic [ALU_OP_W-1:0]   exAluOperation,
  output logic                  exPcUpdate,
  output logic                  exPcAdderSrc,
  output logic [REG_ADDR_W-1:0] exRd,
  output logic                  memReadEnable,
  output logic                  memWriteEnable,
  output logic [REG_ADDR_W-1:0] memRd,
  output logic                  wbRegWriteEnable,
  output logic                  wbFromMemory,
  output logic [REG_ADDR_W-1:0] wbRd,
  output logic                  loadUseStall,
  output logic                  illegalOpcode
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic                  valid;
    logic [1:0]            aluSrc1;
    logic [1:0]            aluSrc2;
    logic [ALU_OP_W-1:0]   aluOp;
    logic                  pcUpdate;
    logic                  pcAdderSrc;
    logic                  memRead;
    logic                  memWrite;
    logic                  regWrite;
    logic                  fromMem;
    logic [REG_ADDR_W-1:0] rd;
  } ctrlBundle_t;

  ctrlBundle_t               rawCtrl;
  ctrlBundle_t               idCtrl;
  ctrlBundle_t               exCtrl;
  logic                      opKnown;
  logic                      idIllegal;
  logic                      memValidQ, memReadQ, memWriteQ, memRegWriteQ, memFromMemQ;
  logic [REG_ADDR_W-1:0]     memRdQ;
  logic                      wbValidQ, wbRegWriteQ, wbFromMemQ;
  logic [REG_ADDR_W-1:0]     wbRdQ;
  logic                      illegalQ;

  // Opcode decode table
  always_comb begin : decode
    rawCtrl = '0;
    opKnown = 1'b1;
    case (opcode)
      OP_R: begin
        rawCtrl.regWrite = 1'b1;
        rawCtrl.aluOp    = ALU_OP_W'(3'b010);
      end
      OP_I: begin
        rawCtrl.regWrite = 1'b1;
        rawCtrl.aluSrc2  = 2'b01;
        rawCtrl.aluOp    = ALU_OP_W'(3'b011);
      end
      OP_LOAD: begin
        rawCtrl.memRead  = 1'b1;
        rawCtrl.regWrite = 1'b1;
        rawCtrl.fromMem  = 1'b1;
        rawCtrl.aluSrc2  = 2'b01;
        rawCtrl.aluOp    = ALU_OP_W'(3'b000);
      end
      OP_S: begin
        rawCtrl.memWrite = 1'b1;
        rawCtrl.aluSrc2  = 2'b01;
        rawCtrl.aluOp    = ALU_OP_W'(3'b000);
      end
      OP_B: begin
        rawCtrl.pcUpdate = 1'b1;
        rawCtrl.aluOp    = ALU_OP_W'(3'b001);
      end
      OP_JAL: begin
        rawCtrl.pcUpdate = 1'b1;
        rawCtrl.regWrite = 1'b1;
        rawCtrl.aluSrc1  = 2'b01;
        rawCtrl.aluSrc2  = 2'b10;
        rawCtrl.aluOp    = ALU_OP_W'(3'b100);
      end
      OP_JALR: begin
        rawCtrl.pcUpdate   = 1'b1;
        rawCtrl.pcAdderSrc = 1'b1;
        rawCtrl.regWrite   = 1'b1;
        rawCtrl.aluSrc1    = 2'b01;
        rawCtrl.aluSrc2    = 2'b10;
        rawCtrl.aluOp      = ALU_OP_W'(3'b101);
      end
      OP_LUI: begin
        rawCtrl.regWrite = 1'b1;
        rawCtrl.aluSrc1  = 2'b10;
        rawCtrl.aluSrc2  = 2'b01;
        rawCtrl.aluOp    = ALU_OP_W'(3'b110);
      end
      OP_AUIPC: begin
        rawCtrl.regWrite = 1'b1;
        rawCtrl.aluSrc1  = 2'b01;
        rawCtrl.aluSrc2  = 2'b01;
        rawCtrl.aluOp    = ALU_OP_W'(3'b111);
      end
      default: opKnown = 1'b0;
    endcase
  end

  // Only a real, known instruction becomes a valid bundle; everything else is a bubble
  always_comb begin : idBundle
    idCtrl    = '0;
    idIllegal = idValid & ~opKnown;
    if (idValid && opKnown) begin
      idCtrl       = rawCtrl;
      idCtrl.valid = 1'b1;
      idCtrl.rd    = idRd;
    end
  end

`ifdef HAZARD_DETECT_EN
  logic usesRs1, usesRs2, rs1Hit, rs2Hit;

  // Which source registers the ID instruction actually reads
  always_comb begin : srcUse
    usesRs1 = 1'b0;
    usesRs2 = 1'b0;
    case (opcode)
      OP_R, OP_S, OP_B: begin
        usesRs1 = 1'b1;
        usesRs2 = 1'b1;
      end
      OP_I, OP_LOAD, OP_JALR: usesRs1 = 1'b1;
      default: ;
    endcase
  end

  assign rs1Hit = usesRs1 && (exCtrl.rd == idRs1);
  assign rs2Hit = usesRs2 && (exCtrl.rd == idRs2);
  assign loadUseStall = ~stall & ~flush & exCtrl.valid & exCtrl.memRead &
                        (exCtrl.rd != '0) & idValid & (rs1Hit | rs2Hit);
`else
  // Source indices only feed hazard detection, which is not built here
  logic unusedSrcIndices;
  assign unusedSrcIndices = ^{idRs1, idRs2};
  assign loadUseStall     = 1'b0;
`endif

  // Stage registers: stall freezes everything; flush or load-use injects a bubble into ID/EX
  always_ff @(posedge clk or negedge resetN) begin : pipeRegs
    if (!resetN) begin
      exCtrl       <= '0;
      illegalQ     <= 1'b0;
      memValidQ    <= 1'b0;
      memReadQ     <= 1'b0;
      memWriteQ    <= 1'b0;
      memRegWriteQ <= 1'b0;
      memFromMemQ  <= 1'b0;
      memRdQ       <= '0;
      wbValidQ     <= 1'b0;
      wbRegWriteQ  <= 1'b0;
      wbFromMemQ   <= 1'b0;
      wbRdQ        <= '0;
    end else if (!stall) begin
      if (flush || loadUseStall) begin
        exCtrl   <= '0;
        illegalQ <= 1'b0;
      end else begin
        exCtrl   <= idCtrl;
        illegalQ <= idIllegal;
      end
      memValidQ    <= exCtrl.valid;
      memReadQ     <= exCtrl.memRead;
      memWriteQ    <= exCtrl.memWrite;
      memRegWriteQ <= exCtrl.regWrite;
      memFromMemQ  <= exCtrl.fromMem;
      memRdQ       <= exCtrl.rd;
      wbValidQ     <= memValidQ;
      wbRegWriteQ  <= memRegWriteQ;
      wbFromMemQ   <= memFromMemQ;
      wbRdQ        <= memRdQ;
    end
  end

  assign exValid          = exCtrl.valid;
  assign exAluSrc1        = exCtrl.aluSrc1;
  assign exAluSrc2        = exCtrl.aluSrc2;
  assign exAluOperation   = exCtrl.aluOp;
  assign exPcUpdate       = exCtrl.pcUpdate;
  assign exPcAdderSrc     = exCtrl.pcAdderSrc;
  assign exRd             = exCtrl.rd;
  assign illegalOpcode    = illegalQ;
  assign memValid         = memValidQ;
  assign memReadEnable    = memReadQ;
  assign memWriteEnable   = memWriteQ;
  assign memRd            = memRdQ;
  assign wbValid          = wbValidQ;
  assign wbRegWriteEnable = wbRegWriteQ;
  assign wbFromMemory     = wbFromMemQ;
  assign wbRd             = wbRdQ;

endmodule

// File: tb/tb_control_pipeline_unit.sv
// Self-checking bench for control_pipeline_unit: decode table stream plus hazard, flush, stall and reset sequences.
module tb_control_pipeline_unit;

`ifdef HAZARD_DETECT_EN
  localparam logic HZ = 1'b1;
`else
  localparam logic HZ = 1'b0;
`endif

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, BAD = 7'b1111111;

  logic       clk, resetN, idValid, stall, flush;
  logic [6:0] opcode;
  logic [4:0] idRd, idRs1, idRs2;
  logic       exValid, memValid, wbValid, exPcUpdate, exPcAdderSrc;
  logic [1:0] exAluSrc1, exAluSrc2;
  logic [2:0] exAluOperation;
  logic [4:0] exRd, memRd, wbRd;
  logic       memReadEnable, memWriteEnable, wbRegWriteEnable, wbFromMemory;
  logic       loadUseStall, illegalOpcode;

  int checks = 0;
  int failures = 0;

  control_pipeline_unit dut (
    .clk(clk), .resetN(resetN), .idValid(idValid), .opcode(opcode),
    .idRd(idRd), .idRs1(idRs1), .idRs2(idRs2), .stall(stall), .flush(flush),
    .exValid(exValid), .memValid(memValid), .wbValid(wbValid),
    .exAluSrc1(exAluSrc1), .exAluSrc2(exAluSrc2), .exAluOperation(exAluOperation),
    .exPcUpdate(exPcUpdate), .exPcAdderSrc(exPcAdderSrc), .exRd(exRd),
    .memReadEnable(memReadEnable), .memWriteEnable(memWriteEnable), .memRd(memRd),
    .wbRegWriteEnable(wbRegWriteEnable), .wbFromMemory(wbFromMemory), .wbRd(wbRd),
    .loadUseStall(loadUseStall), .illegalOpcode(illegalOpcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [6:0] opcode;
    logic       idValid;
    logic       valid;
    logic [1:0] s1, s2;
    logic [2:0] op;
    logic       pcU, add, memR, memW, regW, fromMem, illegal;
  } vec_t;

  localparam int N = 11;
  vec_t vecs[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setId(input logic v, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    idValid = v; opcode = op; idRd = rd; idRs1 = rs1; idRs2 = rs2;
  endtask

  task automatic drain();
    setId(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    repeat (3) tick();
  endtask

  function automatic logic [31:0] exAct();
    return 32'({exValid, exAluSrc1, exAluSrc2, exAluOperation, exPcUpdate, exPcAdderSrc, exRd, illegalOpcode});
  endfunction

  function automatic logic [31:0] exExp(input logic v, input logic [1:0] s1, input logic [1:0] s2,
                                        input logic [2:0] op, input logic pcU, input logic add,
                                        input logic [4:0] rd, input logic ill);
    return 32'({v, s1, s2, op, pcU, add, rd, ill});
  endfunction

  function automatic logic [31:0] memAct();
    return 32'({memValid, memReadEnable, memWriteEnable, memRd});
  endfunction

  function automatic logic [31:0] wbAct();
    return 32'({wbValid, wbRegWriteEnable, wbFromMemory, wbRd});
  endfunction

  initial begin
    //            opcode idV  vld  s1     s2     op    pcU   add   memR  memW  regW  fMem  ill
    vecs[0]  = '{R,     1'b1, 1'b1, 2'd0, 2'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{I,     1'b1, 1'b1, 2'd0, 2'd1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{LD,    1'b1, 1'b1, 2'd0, 2'd1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{ST,    1'b1, 1'b1, 2'd0, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{BR,    1'b1, 1'b1, 2'd0, 2'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{JAL,   1'b1, 1'b1, 2'd1, 2'd2, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{JALR,  1'b1, 1'b1, 2'd1, 2'd2, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{LUI,   1'b1, 1'b1, 2'd2, 2'd1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{AUIPC, 1'b1, 1'b1, 2'd1, 2'd1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{BAD,   1'b1, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{R,     1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    resetN = 1'b0; stall = 1'b0; flush = 1'b0;
    setId(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    repeat (2) tick();
    check("reset_ex", exAct(), 32'd0);
    check("reset_mem", memAct(), 32'd0);
    check("reset_wb", wbAct(), 32'd0);
    #2 resetN = 1'b1;
    tick();

    // Back-to-back decode stream: after edge c, EX=vec[c], MEM=vec[c-1], WB=vec[c-2]
    for (int c = 0; c < N + 2; c++) begin
      if (c < N) setId(vecs[c].idValid, vecs[c].opcode, 5'(c + 1), 5'd0, 5'd0);
      else       setId(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      tick();
      if (c < N)
        check($sformatf("ex_vec%0d", c), exAct(),
              exExp(vecs[c].valid, vecs[c].s1, vecs[c].s2, vecs[c].op, vecs[c].pcU, vecs[c].add,
                    vecs[c].valid ? 5'(c + 1) : 5'd0, vecs[c].illegal));
      if (c >= 1 && c - 1 < N)
        check($sformatf("mem_vec%0d", c - 1), memAct(),
              32'({vecs[c-1].valid, vecs[c-1].memR, vecs[c-1].memW, vecs[c-1].valid ? 5'(c) : 5'd0}));
      if (c >= 2)
        check($sformatf("wb_vec%0d", c - 2), wbAct(),
              32'({vecs[c-2].valid, vecs[c-2].regW, vecs[c-2].fromMem, vecs[c-2].valid ? 5'(c - 1) : 5'd0}));
    end

    // Load-use: LOAD x5 then R reading x5
    drain();
    setId(1'b1, LD, 5'd5, 5'd0, 5'd0);
    tick();
    setId(1'b1, R, 5'd6, 5'd5, 5'd0);
    #1 check("lu_detect", 32'(loadUseStall), 32'(HZ));
    tick();
    check("lu_bubble_ex", 32'(exValid), HZ ? 32'd0 : 32'd1);
    check("lu_load_mem", memAct(), 32'({1'b1, 1'b1, 1'b0, 5'd5}));
    check("lu_after_bubble", 32'(loadUseStall), 32'd0);
    tick();
    check("lu_r_in_ex", exAct(), exExp(1'b1, 2'd0, 2'd0, 3'd2, 1'b0, 1'b0, 5'd6, 1'b0));
    check("lu_load_wb", wbAct(), 32'({1'b1, 1'b1, 1'b1, 5'd5}));

    // No-hazard cases and stall/flush masking of the hazard
    drain();
    setId(1'b1, LD, 5'd0, 5'd0, 5'd0);
    tick();
    setId(1'b1, R, 5'd6, 5'd0, 5'd0);
    #1 check("nohz_rd0", 32'(loadUseStall), 32'd0);
    setId(1'b1, LD, 5'd5, 5'd0, 5'd0);
    tick();
    setId(1'b1, LUI, 5'd7, 5'd5, 5'd5);
    #1 check("nohz_lui", 32'(loadUseStall), 32'd0);
    setId(1'b1, ST, 5'd0, 5'd1, 5'd5);
    #1 check("hz_store_rs2", 32'(loadUseStall), 32'(HZ));
    stall = 1'b1;
    #1 check("hz_masked_stall", 32'(loadUseStall), 32'd0);
    stall = 1'b0; flush = 1'b1;
    #1 check("hz_masked_flush", 32'(loadUseStall), 32'd0);
    flush = 1'b0;

    // Flush with JAL in EX
    drain();
    setId(1'b1, JAL, 5'd1, 5'd0, 5'd0);
    tick();
    setId(1'b1, I, 5'd2, 5'd0, 5'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    setId(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    check("flush_ex_bubble", exAct(), 32'd0);
    check("flush_jal_mem", memAct(), 32'({1'b1, 1'b0, 1'b0, 5'd1}));
    tick();
    check("flush_jal_wb", wbAct(), 32'({1'b1, 1'b1, 1'b0, 5'd1}));

    // stall together with flush holds every stage
    drain();
    setId(1'b1, R, 5'd7, 5'd0, 5'd0);
    tick();
    setId(1'b1, I, 5'd8, 5'd0, 5'd0);
    tick();
    setId(1'b1, LUI, 5'd9, 5'd0, 5'd0);
    stall = 1'b1; flush = 1'b1;
    tick();
    check("stallflush_ex", exAct(), exExp(1'b1, 2'd0, 2'd1, 3'd3, 1'b0, 1'b0, 5'd8, 1'b0));
    check("stallflush_mem", memAct(), 32'({1'b1, 1'b0, 1'b0, 5'd7}));
    check("stallflush_wb", wbAct(), 32'd0);
    stall = 1'b0; flush = 1'b0;

    // Illegal opcode flag holds under stall, clears on advance
    drain();
    setId(1'b1, BAD, 5'd3, 5'd0, 5'd0);
    tick();
    check("illegal_set", exAct(), exExp(1'b0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b1));
    setId(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    stall = 1'b1;
    tick();
    check("illegal_hold", 32'(illegalOpcode), 32'd1);
    stall = 1'b0;
    tick();
    check("illegal_clear", 32'(illegalOpcode), 32'd0);

    // Asynchronous reset mid-stream
    setId(1'b1, R, 5'd9, 5'd0, 5'd0);
    repeat (2) tick();
    resetN = 1'b0;
    #1;
    check("areset_ex", exAct(), 32'd0);
    check("areset_mem", memAct(), 32'd0);
    check("areset_wb", wbAct(), 32'd0);
    setId(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    #2 resetN = 1'b1;
    tick();
    check("areset_restart", 32'({exValid, memValid, wbValid}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
